out_serial_tx: RTL



---
 rtl/out_serial_tx_pkg.sv | 16 +
 rtl/byte_fifo.sv | 65 ++++++
 rtl/out_serial_tx_defs.svh | 14 +
 rtl/out_serial_tx.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/out_serial_tx_pkg.sv
// Types and constants shared by the serial transmitter and its FIFO.
package out_serial_tx_pkg;

`include "out_serial_tx_defs.svh"

   typedef enum logic [1:0] {
      StIdle  = `OST_ST_IDLE,
      StStart = `OST_ST_START,
      StData  = `OST_ST_DATA,
      StStop  = `OST_ST_STOP
   } tx_state_e;

   localparam int unsigned FrameBits = `OST_FRAME_BITS;
   localparam int unsigned DataBits  = 8;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO; a push while full is still accepted if a pop lands on the same edge.
module byte_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [7:0]             din,
   input  logic                   pop,
   output logic [7:0]             dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [7:0]      mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; a write on a reset edge is discarded
   always_ff @(posedge clk) begin
      if (!reset && push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/out_serial_tx_defs.svh
// Shared encodings for the serial transmitter FSM and frame geometry.
// Also pulled in by the console decoder on the bench side via the package.
`ifndef OUT_SERIAL_TX_DEFS_SVH
`define OUT_SERIAL_TX_DEFS_SVH

`define OST_ST_IDLE  2'd0
`define OST_ST_START 2'd1
`define OST_ST_DATA  2'd2
`define OST_ST_STOP  2'd3

// Start + 8 data + stop
`define OST_FRAME_BITS 10

`endif

// File: rtl/out_serial_tx.sv
// 8N1 serial transmitter fed from the CPU output strobe through a small FIFO.
module out_serial_tx
   import out_serial_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned DEPTH        = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   doOut,
   input  logic [7:0]             dbus,
   output logic                   tx,
   output logic                   busy,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int unsigned         CycW    = $clog2(CLKS_PER_BIT);
   localparam logic [CycW-1:0]     CycLast = CycW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]          BitLast = 3'(DataBits - 1);

   tx_state_e             state_q, state_d;
   logic                  tx_q, tx_d;
   logic [DataBits-1:0]   shift_q, shift_d;
   logic [2:0]            bit_q, bit_d;
   logic [CycW-1:0]       cyc_q, cyc_d;
   logic                  overflow_q, overflow_d;
   logic                  pop;
   logic [7:0]            fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  cyc_last;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (doOut),
      .din   (dbus),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cyc_last = (cyc_q == CycLast);
   assign tx       = tx_q;
   assign full     = fifo_full;
   assign overflow = overflow_q;
   assign busy     = (state_q != StIdle) | ~fifo_empty;

   // A write is only dropped when full and no pop frees a slot on the same edge
   always_comb begin
      overflow_d = overflow_q | (doOut & fifo_full & ~pop);
   end

   // Frame sequencing: start bit, eight data bits LSB first, stop bit
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      cyc_d   = cyc_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               tx_d    = 1'b0;
               cyc_d   = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (cyc_last) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               cyc_d   = '0;
               state_d = StData;
            end else begin
               cyc_d = cyc_q + CycW'(1);
            end
         end
         StData: begin
            if (cyc_last) begin
               cyc_d = '0;
               if (bit_q == BitLast) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               cyc_d = cyc_q + CycW'(1);
            end
         end
         StStop: begin
            if (cyc_last) begin
               cyc_d = '0;
               // Queued data starts the next frame with no idle gap
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_dout;
                  tx_d    = 1'b0;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cyc_d = cyc_q + CycW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, line and sticky flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         tx_q       <= 1'b1;
         shift_q    <= '0;
         bit_q      <= '0;
         cyc_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         shift_q    <= shift_d;
         bit_q      <= bit_d;
         cyc_q      <= cyc_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
